// File: rtl/satd_pkg.sv
// Shared SATD datapath definitions: lane/row geometry, default widths and the
// row-index type used by the control, Hadamard and accumulate stages.
package satd_pkg;

  localparam int LANES    = 4;
  localparam int ROWS     = 4;
  localparam int IN_W_DEF = 13;

  typedef logic [1:0] row_idx_t;

  // Sixteen magnitudes of up to 2^(in_w-1) each need four extra bits.
  function automatic int sum_w(input int in_w);
    return in_w + 4;
  endfunction

endpackage

// File: rtl/satd_abs_acc_if.sv
// Coefficient-row input bus and SATD result bus of the abs/accumulate stage.
interface satd_abs_acc_if
  import satd_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int SUM_W = sum_w(IN_W)
);

  logic                    in_valid;
  logic                    in_last;
  logic [LANES*IN_W-1:0]   in_coef;
  logic                    clr_err;
  logic                    satd_valid;
  logic [SUM_W-1:0]        satd;
  logic                    busy;
  logic                    proto_err;

  modport master (
    output in_valid, in_last, in_coef, clr_err,
    input  satd_valid, satd, busy, proto_err
  );

  modport slave (
    input  in_valid, in_last, in_coef, clr_err,
    output satd_valid, satd, busy, proto_err
  );

endinterface

// File: rtl/satd_abs_acc_abs_lane.sv
// One-lane registered absolute value: signed IN_W in, unsigned IN_W out.
// The most negative input maps exactly onto 2^(IN_W-1).
module abs_lane #(
  parameter int IN_W = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic signed [IN_W-1:0] coef,
  output logic [IN_W-1:0]        mag
);

  logic [IN_W-1:0] coef_u_s;
  logic [IN_W-1:0] mag_s;

  // two's-complement negate when the sign bit is set
  always_comb begin
    coef_u_s = coef;
    if (coef_u_s[IN_W-1]) begin
      mag_s = ~coef_u_s + {{(IN_W-1){1'b0}}, 1'b1};
    end else begin
      mag_s = coef_u_s;
    end
  end

  // magnitude register, loaded on every accepted row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= {IN_W{1'b0}};
    end else if (en) begin
      mag <= mag_s;
    end
  end

endmodule

// File: rtl/satd_abs_acc.sv
// SATD abs/accumulate stage: |coef| per lane, row sums accumulated over four
// rows, SATD = (sum + 1) >> 1 strobed two cycles after the last row.
module satd_abs_acc
  import satd_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int SUM_W = sum_w(IN_W)
) (
  input  logic            clk,
  input  logic            rst_n,
  satd_abs_acc_if.slave   bus
);

  localparam row_idx_t LAST_ROW = row_idx_t'(ROWS - 1);

  row_idx_t          row_idx_r, row_idx_nxt_s;
  logic              err_s, kill_a_s, accept_s, b_load_s;
  logic [IN_W-1:0]   mag_r [LANES];
  logic              a_valid_r, a_first_r, a_last_r;
  logic              b_valid_r, b_last_r;
  logic [IN_W+1:0]   row_sum_s;
  logic [SUM_W-1:0]  acc_r, acc_nxt_s, satd_nxt_s;
  logic              satd_valid_r, proto_err_r;
  logic [SUM_W-1:0]  satd_r;

  // row-count check; an error also kills the same block's beat in stage A
  always_comb begin
    err_s         = 1'b0;
    row_idx_nxt_s = row_idx_r;
    if (bus.in_valid) begin
      err_s = bus.in_last ^ (row_idx_r == LAST_ROW);
      if (err_s) begin
        row_idx_nxt_s = row_idx_t'(2'd0);
      end else begin
        row_idx_nxt_s = row_idx_r + row_idx_t'(2'd1);
      end
    end else begin
      err_s = 1'b0;
    end
    kill_a_s = err_s & (row_idx_r != row_idx_t'(2'd0));
    accept_s = bus.in_valid & ~err_s;
    b_load_s = a_valid_r & ~kill_a_s;
  end

  // row index and sticky protocol error (a new error beats clr_err)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx_r   <= row_idx_t'(2'd0);
      proto_err_r <= 1'b0;
    end else begin
      row_idx_r <= row_idx_nxt_s;
      if (err_s) begin
        proto_err_r <= 1'b1;
      end else if (bus.clr_err) begin
        proto_err_r <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    abs_lane #(.IN_W(IN_W)) u_abs (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.in_valid),
      .coef  (bus.in_coef[k*IN_W +: IN_W]),
      .mag   (mag_r[k])
    );
  end

  // stage A side-band: valid, first-row and last-row flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_r <= 1'b0;
      a_first_r <= 1'b0;
      a_last_r  <= 1'b0;
    end else begin
      a_valid_r <= accept_s;
      if (bus.in_valid) begin
        a_first_r <= (row_idx_r == row_idx_t'(2'd0));
        a_last_r  <= bus.in_last;
      end
    end
  end

  // row sum, accumulate (load on the first row) and rounding halve
  always_comb begin
    row_sum_s = {(IN_W+2){1'b0}};
    for (int k = 0; k < LANES; k++) begin
      row_sum_s = row_sum_s + {2'b00, mag_r[k]};
    end
    if (a_first_r) begin
      acc_nxt_s = {{(SUM_W-IN_W-2){1'b0}}, row_sum_s};
    end else begin
      acc_nxt_s = acc_r + {{(SUM_W-IN_W-2){1'b0}}, row_sum_s};
    end
    satd_nxt_s = (acc_r >> 1) + {{(SUM_W-1){1'b0}}, acc_r[0]};
  end

  // stage B accumulator and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_r    <= 1'b0;
      b_last_r     <= 1'b0;
      acc_r        <= {SUM_W{1'b0}};
      satd_valid_r <= 1'b0;
      satd_r       <= {SUM_W{1'b0}};
    end else begin
      b_valid_r    <= b_load_s;
      b_last_r     <= a_last_r;
      satd_valid_r <= b_valid_r & b_last_r;
      if (b_load_s) begin
        acc_r <= acc_nxt_s;
      end
      if (b_valid_r & b_last_r) begin
        satd_r <= satd_nxt_s;
      end
    end
  end

  assign bus.satd_valid = satd_valid_r;
  assign bus.satd       = satd_r;
  assign bus.proto_err  = proto_err_r;
  assign bus.busy       = (row_idx_r != row_idx_t'(2'd0)) | a_valid_r | b_valid_r;

endmodule

// File: tb/tb_satd_abs_acc.sv
// Directed self-checking bench for satd_abs_acc with hand-computed SATD values.
module tb_satd_abs_acc;
  import satd_pkg::*;

  localparam int IN_W  = 13;
  localparam int SUM_W = 17;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  satd_abs_acc_if #(.IN_W(IN_W), .SUM_W(SUM_W)) bus ();

  satd_abs_acc #(.IN_W(IN_W), .SUM_W(SUM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4*IN_W-1:0] pack(input int a, input int b, input int c, input int d);
    logic [IN_W-1:0] ta, tb_, tc, td;
    ta = a[IN_W-1:0];
    tb_ = b[IN_W-1:0];
    tc = c[IN_W-1:0];
    td = d[IN_W-1:0];
    return {td, tc, tb_, ta};
  endfunction

  task automatic send_row(input logic [4*IN_W-1:0] coef, input logic last);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.in_coef  = coef;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_block(input logic [4*IN_W-1:0] coef);
    send_row(coef, 1'b0);
    send_row(coef, 1'b0);
    send_row(coef, 1'b0);
    send_row(coef, 1'b1);
  endtask

  // called right after the last-row edge with no further input
  task automatic finish_block(input string tag, input int exp);
    check({tag, "_sv_t0"}, 32'(bus.satd_valid), 32'd0);
    step();
    check({tag, "_sv_t1"}, 32'(bus.satd_valid), 32'd0);
    step();
    check({tag, "_sv_t2"}, 32'(bus.satd_valid), 32'd1);
    check({tag, "_satd"}, 32'(bus.satd), 32'(exp));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    step();
    check({tag, "_sv_t3"}, 32'(bus.satd_valid), 32'd0);
  endtask

  task automatic clear_err();
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    check("clr_err", 32'(bus.proto_err), 32'd0);
  endtask

  initial begin
    logic [4*IN_W-1:0] p1, p2, p5, pm, pn;
    checks = 0;
    errors = 0;
    p1 = pack(1, 1, 1, 1);
    p2 = pack(2, 2, 2, 2);
    p5 = pack(5, 5, 5, 5);
    pm = pack(-3, 5, -7, 2);
    pn = pack(-4096, -4096, -4096, -4096);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_coef  = '0;
    bus.clr_err  = 1'b0;
    step();
    step();
    check("rst_sv", 32'(bus.satd_valid), 32'd0);
    check("rst_satd", 32'(bus.satd), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.proto_err), 32'd0);
    rst_n = 1'b1;
    step();

    // all +1: sum 16 -> 8
    send_row(p1, 1'b0);
    check("t1_busy_mid", 32'(bus.busy), 32'd1);
    send_row(p1, 1'b0);
    send_row(p1, 1'b0);
    send_row(p1, 1'b1);
    check("t1_busy_last", 32'(bus.busy), 32'd1);
    finish_block("t1", 8);
    check("t1_hold", 32'(bus.satd), 32'd8);

    // mixed signs: 4 * 17 = 68 -> 34, back-to-back rows then gapped rows
    send_block(pm);
    finish_block("t2", 34);
    for (int r = 0; r < 4; r++) begin
      send_row(pm, (r == 3) ? 1'b1 : 1'b0);
      if (r != 3) begin
        step();
        step();
        check("t2g_busy_gap", 32'(bus.busy), 32'd1);
      end
    end
    finish_block("t2g", 34);

    // most negative input: 16 * 4096 = 65536 -> 32768
    send_block(pn);
    finish_block("t3", 32768);

    // back-to-back blocks: +1 then +2 -> 8 then 16, strobes 4 cycles apart
    send_block(p1);
    send_row(p2, 1'b0);
    check("t4_sv_a", 32'(bus.satd_valid), 32'd0);
    send_row(p2, 1'b0);
    check("t4_sv_b", 32'(bus.satd_valid), 32'd1);
    check("t4_satd1", 32'(bus.satd), 32'd8);
    send_row(p2, 1'b0);
    check("t4_sv_c", 32'(bus.satd_valid), 32'd0);
    send_row(p2, 1'b1);
    finish_block("t4b", 16);

    // in_last on row 1 -> error, block dropped
    send_row(p5, 1'b0);
    send_row(p5, 1'b1);
    check("t5_err", 32'(bus.proto_err), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_sv", 32'(bus.satd_valid), 32'd0);
    end
    send_block(p1);
    finish_block("t5_clean", 8);
    check("t5_sticky", 32'(bus.proto_err), 32'd1);
    clear_err();

    // fourth row without in_last -> error, no result
    send_row(p2, 1'b0);
    send_row(p2, 1'b0);
    send_row(p2, 1'b0);
    send_row(p2, 1'b0);
    check("t5b_err", 32'(bus.proto_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5b_no_sv", 32'(bus.satd_valid), 32'd0);
    end
    clear_err();

    // clr_err coinciding with a new mismatch: error wins
    bus.clr_err = 1'b1;
    send_row(p1, 1'b1);
    bus.clr_err = 1'b0;
    check("t5c_err_wins", 32'(bus.proto_err), 32'd1);
    step();
    check("t5c_no_sv", 32'(bus.satd_valid), 32'd0);
    clear_err();

    // async reset after two rows; fresh block unaffected
    send_row(p5, 1'b0);
    send_row(p5, 1'b0);
    check("t6_busy_pre", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_sv", 32'(bus.satd_valid), 32'd0);
    check("t6_satd", 32'(bus.satd), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_err", 32'(bus.proto_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send_block(p1);
    finish_block("t6_fresh", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
